ram_sequencer: RTL and testbench

RAM_SEQUENCER -- requirements
Module: ram_sequencer

---
 rtl/ram_sequencer_pkg.sv | 21 ++
 rtl/ram_sequencer_if.sv | 45 ++++
 rtl/ram_sequencer_ptr_counter.sv | 46 ++++
 rtl/ram_sequencer.sv | 142 ++++++++++++++
 tb/tb_ram_sequencer.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/ram_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ram_sequencer_pkg
// Brief    : Shared sizing defaults and FSM encoding for the RAM sequencer.
// Revision : 1.0
// ============================================================================
package ram_sequencer_pkg;

  localparam int c_INDEX_PTR  = 2;
  localparam int c_QUEUE_SIZE = 2 ** c_INDEX_PTR;
  localparam int c_DATA_SIZE  = 128;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SERVE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/ram_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : ram_sequencer_if
// Brief    : Job, producer, RAM and hash-core signals of the RAM sequencer.
// Revision : 1.0
// ============================================================================
interface ram_sequencer_if
  import ram_sequencer_pkg::*;
#(
  parameter int INDEX_PTR = c_INDEX_PTR,
  parameter int DATA_SIZE = c_DATA_SIZE
);

  logic                 start;
  logic [INDEX_PTR:0]   job_len;
  logic                 abort;
  logic                 in_valid;
  logic [DATA_SIZE-1:0] in_data;
  logic                 in_ready;
  logic                 ram_wr_en;
  logic [INDEX_PTR-1:0] ram_wr_addr;
  logic [DATA_SIZE-1:0] ram_wr_data;
  logic                 next;
  logic [INDEX_PTR-1:0] ram_rd_addr;
  logic                 core_req;
  logic                 core_valid;
  logic                 busy;
  logic                 done;

  // Environment side: job control, producer and hash core.
  modport master (
    output start, job_len, abort, in_valid, in_data, core_req,
    input  in_ready, ram_wr_en, ram_wr_addr, ram_wr_data, next,
           ram_rd_addr, core_valid, busy, done
  );

  // Sequencer side.
  modport slave (
    input  start, job_len, abort, in_valid, in_data, core_req,
    output in_ready, ram_wr_en, ram_wr_addr, ram_wr_data, next,
           ram_rd_addr, core_valid, busy, done
  );

endinterface
`default_nettype wire

// File: rtl/ram_sequencer_ptr_counter.sv
`default_nettype none
// ============================================================================
// Module   : ptr_counter
// Brief    : Wrapping RAM pointer with synchronous clear and increment.
// Revision : 1.0
// ============================================================================
module ptr_counter
  import ram_sequencer_pkg::*;
#(
  parameter int INDEX_PTR  = c_INDEX_PTR,
  parameter int QUEUE_SIZE = c_QUEUE_SIZE
) (
  input  wire                  clk,
  input  wire                  reset_L,
  input  wire                  clr,
  input  wire                  inc,
  output logic [INDEX_PTR-1:0] ptr
);

  localparam logic [INDEX_PTR-1:0] c_LAST = INDEX_PTR'(QUEUE_SIZE - 1);

  logic [INDEX_PTR-1:0] ptr_d;
  logic [INDEX_PTR-1:0] ptr_q;

  // Explicit wrap keeps non-power-of-two depths correct.
  always_comb begin
    ptr_d = ptr_q;
    if (clr) begin
      ptr_d = '0;
    end else if (inc) begin
      ptr_d = (ptr_q == c_LAST) ? '0 : ptr_q + INDEX_PTR'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule
`default_nettype wire

// File: rtl/ram_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : ram_sequencer
// Brief    : Loads a job of words into a RAM, then streams them to a hash core.
// Revision : 1.0
// ============================================================================
module ram_sequencer
  import ram_sequencer_pkg::*;
#(
  parameter int INDEX_PTR  = c_INDEX_PTR,
  parameter int QUEUE_SIZE = 2 ** INDEX_PTR,
  parameter int DATA_SIZE  = c_DATA_SIZE
) (
  input wire             clk,
  input wire             reset_L,
  ram_sequencer_if.slave bus
);

  localparam int LW = INDEX_PTR + 1;
  localparam logic [LW-1:0] c_QMAX = LW'(QUEUE_SIZE);

  state_t          state_q, state_d;
  logic [LW-1:0]   len_q, len_d;
  logic [LW-1:0]   wr_cnt_q, wr_cnt_d;
  logic [LW-1:0]   rd_cnt_q, rd_cnt_d;
  logic            core_valid_q, core_valid_d;

  logic                 w_accept;
  logic                 w_write;
  logic                 w_read;
  logic                 w_clr;
  logic [LW-1:0]        w_len_clamped;
  logic [INDEX_PTR-1:0] w_wr_ptr;
  logic [INDEX_PTR-1:0] w_rd_ptr;

  always_comb begin
    w_len_clamped = (bus.job_len > c_QMAX) ? c_QMAX : bus.job_len;
    w_accept = (state_q == ST_IDLE) && bus.start && (bus.job_len != '0) && !bus.abort;
    // abort outranks both the producer write and the core read in the same cycle
    w_write  = (state_q == ST_LOAD) && bus.in_valid && !bus.abort;
    w_read   = (state_q == ST_SERVE) && bus.core_req && (rd_cnt_q < len_q) && !bus.abort;
    w_clr    = bus.abort || w_accept;
  end

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    wr_cnt_d     = wr_cnt_q;
    rd_cnt_d     = rd_cnt_q;
    core_valid_d = w_read;
    if (bus.abort) begin
      state_d  = ST_IDLE;
      len_d    = '0;
      wr_cnt_d = '0;
      rd_cnt_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (w_accept) begin
            state_d  = ST_LOAD;
            len_d    = w_len_clamped;
            wr_cnt_d = '0;
            rd_cnt_d = '0;
          end
        end
        ST_LOAD: begin
          if (w_write) begin
            wr_cnt_d = wr_cnt_q + LW'(1);
            if (wr_cnt_q + LW'(1) == len_q) begin
              state_d = ST_SERVE;
            end
          end
        end
        ST_SERVE: begin
          if (w_read) begin
            rd_cnt_d = rd_cnt_q + LW'(1);
          end
          // leave once the last read word has been presented to the core
          if (core_valid_q && (rd_cnt_q == len_q)) begin
            state_d = ST_DONE;
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q      <= ST_IDLE;
      len_q        <= '0;
      wr_cnt_q     <= '0;
      rd_cnt_q     <= '0;
      core_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      wr_cnt_q     <= wr_cnt_d;
      rd_cnt_q     <= rd_cnt_d;
      core_valid_q <= core_valid_d;
    end
  end

  ptr_counter #(
    .INDEX_PTR  (INDEX_PTR),
    .QUEUE_SIZE (QUEUE_SIZE)
  ) u_wr_ptr (
    .clk     (clk),
    .reset_L (reset_L),
    .clr     (w_clr),
    .inc     (w_write),
    .ptr     (w_wr_ptr)
  );

  ptr_counter #(
    .INDEX_PTR  (INDEX_PTR),
    .QUEUE_SIZE (QUEUE_SIZE)
  ) u_rd_ptr (
    .clk     (clk),
    .reset_L (reset_L),
    .clr     (w_clr),
    .inc     (w_read),
    .ptr     (w_rd_ptr)
  );

  assign bus.in_ready    = (state_q == ST_LOAD) && !bus.abort;
  assign bus.ram_wr_en   = w_write;
  assign bus.ram_wr_addr = w_wr_ptr;
  assign bus.ram_wr_data = w_write ? bus.in_data : '0;
  assign bus.next        = w_read;
  assign bus.ram_rd_addr = w_rd_ptr;
  assign bus.core_valid  = core_valid_q;
  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.done        = (state_q == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_ram_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_sequencer
// Brief    : Directed self-checking bench for ram_sequencer.
// Revision : 1.0
// ============================================================================
module tb_ram_sequencer;
  import ram_sequencer_pkg::*;

  logic clk;
  logic reset_L;
  int   total;
  int   bad;
  logic [127:0] words [4];

  ram_sequencer_if #(.INDEX_PTR(2), .DATA_SIZE(128)) bus ();

  ram_sequencer #(
    .INDEX_PTR  (2),
    .QUEUE_SIZE (4),
    .DATA_SIZE  (128)
  ) dut (
    .clk     (clk),
    .reset_L (reset_L),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks follow 3 units later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".busy"},       bus.busy,        0);
    chk({tag, ".in_ready"},   bus.in_ready,    0);
    chk({tag, ".wr_en"},      bus.ram_wr_en,   0);
    chk({tag, ".wr_addr"},    bus.ram_wr_addr, 0);
    chk({tag, ".wr_data"},    bus.ram_wr_data, 0);
    chk({tag, ".next"},       bus.next,        0);
    chk({tag, ".rd_addr"},    bus.ram_rd_addr, 0);
    chk({tag, ".core_valid"}, bus.core_valid,  0);
    chk({tag, ".done"},       bus.done,        0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    words[0] = 128'h0123_4567_89ab_cdef_0000_0000_0000_000a;
    words[1] = 128'hffff_0000_ffff_0000_0000_0000_0000_000b;
    words[2] = 128'h8000_0000_0000_0000_0000_0000_0000_000c;
    words[3] = 128'h0000_0000_0000_0000_5555_aaaa_0000_000d;

    // Reset with active inputs: every output must stay at zero.
    reset_L      = 1'b0;
    bus.start    = 1'b1;
    bus.job_len  = 3'd4;
    bus.abort    = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = 128'hdead_beef;
    bus.core_req = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    chk_all_zero("reset");
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.core_req = 1'b0;
    reset_L      = 1'b1;

    // Job of 4 words, written on consecutive cycles.
    step(); bus.start = 1'b1; bus.job_len = 3'd4; #3;
    chk("idle.busy", bus.busy, 0);
    step(); bus.start = 1'b0; bus.in_valid = 1'b1; bus.in_data = words[0]; bus.core_req = 1'b1; #3;
    chk("load0.in_ready", bus.in_ready, 1);
    chk("load0.wr_en", bus.ram_wr_en, 1);
    chk("load0.wr_addr", bus.ram_wr_addr, 0);
    chk("load0.wr_data", bus.ram_wr_data, words[0]);
    chk("load0.next_ignored", bus.next, 0);
    chk("load0.busy", bus.busy, 1);
    for (int i = 1; i < 4; i++) begin
      step(); bus.in_data = words[i]; bus.start = (i == 1); #3;
      chk("load.wr_addr", bus.ram_wr_addr, i);
      chk("load.wr_data", bus.ram_wr_data, words[i]);
    end

    // Serve with core_req held high.
    step(); bus.start = 1'b0; bus.in_valid = 1'b0; #3;
    chk("serve0.in_ready", bus.in_ready, 0);
    chk("serve0.wr_data", bus.ram_wr_data, 0);
    chk("serve0.next", bus.next, 1);
    chk("serve0.rd_addr", bus.ram_rd_addr, 0);
    chk("serve0.core_valid", bus.core_valid, 0);
    for (int i = 1; i < 4; i++) begin
      step(); #3;
      chk("serve.next", bus.next, 1);
      chk("serve.rd_addr", bus.ram_rd_addr, i);
      chk("serve.core_valid", bus.core_valid, 1);
    end
    step(); #3;
    chk("serve_end.next", bus.next, 0);
    chk("serve_end.core_valid", bus.core_valid, 1);
    chk("serve_end.rd_addr", bus.ram_rd_addr, 0);
    chk("serve_end.done", bus.done, 0);
    step(); bus.core_req = 1'b0; #3;
    chk("done.done", bus.done, 1);
    chk("done.core_valid", bus.core_valid, 0);
    chk("done.busy", bus.busy, 1);
    step(); #3;
    chk("post_done.done", bus.done, 0);
    chk("post_done.busy", bus.busy, 0);

    // Zero-length start is ignored.
    step(); bus.start = 1'b1; bus.job_len = 3'd0; #3;
    step(); bus.start = 1'b0; #3;
    chk("len0.busy", bus.busy, 0);
    chk("len0.in_ready", bus.in_ready, 0);

    // job_len=7 clamps to 4 words.
    step(); bus.start = 1'b1; bus.job_len = 3'd7; #3;
    step(); bus.start = 1'b0; bus.in_valid = 1'b1; #3;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        step(); #3;
      end
      chk("clamp.in_ready", bus.in_ready, 1);
      chk("clamp.wr_addr", bus.ram_wr_addr, i);
    end
    step(); bus.in_valid = 1'b0; bus.core_req = 1'b1; bus.abort = 1'b1; #3;
    chk("clamp.serve_in_ready", bus.in_ready, 0);
    chk("clamp.serve_busy", bus.busy, 1);
    chk("serve_abort.next", bus.next, 0);
    step(); bus.abort = 1'b0; bus.core_req = 1'b0; #3;
    chk("serve_abort.busy", bus.busy, 0);
    chk("serve_abort.done", bus.done, 0);

    // Abort after two writes, with in_valid still high.
    step(); bus.start = 1'b1; bus.job_len = 3'd4; #3;
    step(); bus.start = 1'b0; bus.in_valid = 1'b1; bus.in_data = words[2]; #3;
    chk("abort.wr_addr0", bus.ram_wr_addr, 0);
    step(); bus.in_data = words[3]; #3;
    chk("abort.wr_addr1", bus.ram_wr_addr, 1);
    step(); bus.abort = 1'b1; #3;
    chk("abort.wr_en", bus.ram_wr_en, 0);
    step(); bus.abort = 1'b0; bus.in_valid = 1'b0; #3;
    chk("abort.busy", bus.busy, 0);
    chk("abort.done", bus.done, 0);

    // Restart; in_valid toggles 1,0,1,0,... and addresses stay contiguous.
    step(); bus.start = 1'b1; bus.job_len = 3'd4; #3;
    step(); bus.start = 1'b0; #0;
    for (int c = 0; c < 8; c++) begin
      if (c > 0) step();
      bus.in_valid = (c % 2 == 0);
      bus.in_data  = 128'(c + 100);
      #3;
      if (c % 2 == 0) begin
        chk("toggle.wr_en", bus.ram_wr_en, 1);
        chk("toggle.wr_addr", bus.ram_wr_addr, c / 2);
        chk("toggle.wr_data", bus.ram_wr_data, c + 100);
      end else begin
        chk("toggle.idle_wr_en", bus.ram_wr_en, 0);
      end
    end
    chk("toggle.serve_in_ready", bus.in_ready, 0);
    chk("toggle.serve_busy", bus.busy, 1);

    // Reset pulled low mid-serve.
    step(); bus.in_valid = 1'b0; bus.core_req = 1'b1; #3;
    chk("rst_mid.next0", bus.next, 1);
    chk("rst_mid.rd_addr0", bus.ram_rd_addr, 0);
    step(); #3;
    chk("rst_mid.rd_addr1", bus.ram_rd_addr, 1);
    chk("rst_mid.core_valid", bus.core_valid, 1);
    #1 reset_L = 1'b0;
    #1;
    bus.core_req = 1'b0;
    chk_all_zero("rst_mid");
    step(); reset_L = 1'b1; #3;
    chk("rst_rel.busy", bus.busy, 0);
    chk("rst_rel.done", bus.done, 0);
    step(); #3;
    chk("rst_rel2.busy", bus.busy, 0);
    chk("rst_rel2.done", bus.done, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
